// File: rtl/shift_pkg.sv
// Shared definitions for the shift_register command path: op and state
// encodings plus the register width that the sequencer defaults to.
package shift_pkg;

    localparam int SR_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_SHL  = 2'b10,
        OP_SHR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PULSE = 2'b01,
        S_GAP   = 2'b10,
        S_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/shift_step_counter.sv
// Loadable down-counter holding the remaining register operations of a command.
// It saturates at zero so it never wraps.
module shift_step_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && !zero)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Turns one LOAD/SHL/SHR/NOP command into strobe/gap pulses for shift_register,
// then signals completion with a single-cycle done pulse.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] d_out,
    output logic             ld,
    output logic             sl,
    output logic             sr,
    output logic             busy,
    output logic             done
);

    state_e           state, state_nxt;
    op_e              op_q;
    op_e              op_in;
    logic [WIDTH-1:0] d_q;
    logic             accept;
    logic             is_shift;
    logic [CNT_W-1:0] rem_load;
    logic [CNT_W-1:0] rem;
    logic             rem_zero;

    assign op_in    = op_e'(cmd_op);
    assign accept   = cmd_valid && (state == S_IDLE);
    assign is_shift = (op_in == OP_SHL) || (op_in == OP_SHR);
    // NOP loads zero so rem always reflects the work actually outstanding.
    assign rem_load = (op_in == OP_LOAD) ? CNT_W'(1) : (is_shift ? cmd_cnt : '0);

    shift_step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (rem_load),
        .dec      (state == S_PULSE),
        .count    (rem),
        .zero     (rem_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= OP_NOP;
            d_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= op_in;
                if (op_in == OP_LOAD)
                    d_q <= cmd_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (op_in == OP_NOP || (is_shift && cmd_cnt == '0))
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_PULSE;
                end
            end
            S_PULSE: state_nxt = S_GAP;
            S_GAP:   state_nxt = rem_zero ? S_DONE : S_PULSE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes come only from registered state/op, never from the command inputs.
    assign ld        = (state == S_PULSE) && (op_q == OP_LOAD);
    assign sl        = (state == S_PULSE) && (op_q == OP_SHL);
    assign sr        = (state == S_PULSE) && (op_q == OP_SHR);
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign d_out     = d_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a schedule-queue model predicts every output each
// cycle; directed sections pin the model with literal timing expectations.
module tb_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [WIDTH-1:0] d_out;
    logic             ld, sl, sr, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .d_out     (d_out),
        .ld        (ld),
        .sl        (sl),
        .sr        (sr),
        .busy      (busy),
        .done      (done)
    );

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Model: each accepted command expands into a list of per-cycle output
    // vectors {ready, busy, done, ld, sl, sr}; an empty list means idle.
    logic [5:0]       sched[$];
    logic [WIDTH-1:0] exp_dout = '0;
    logic [WIDTH-1:0] shreg = '0;
    logic [5:0]       exp_vec;
    logic [5:0]       mstb;
    int               mn;
    int               accepts = 0;
    bit               chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            sched.delete();
            exp_dout = '0;
        end else if (sched.size() > 0) begin
            void'(sched.pop_front());
        end else if (cmd_valid) begin
            accepts++;
            case (cmd_op)
                2'b01:   begin mn = 1;            mstb = 6'b010100; exp_dout = cmd_data; end
                2'b10:   begin mn = int'(cmd_cnt); mstb = 6'b010010; end
                2'b11:   begin mn = int'(cmd_cnt); mstb = 6'b010001; end
                default: begin mn = 0;            mstb = 6'b010000; end
            endcase
            for (int i = 0; i < mn; i++) begin
                sched.push_back(mstb);
                sched.push_back(6'b010000);
            end
            sched.push_back(6'b011000);
        end
        // Downstream shift_register, fed from the DUT strobes of the ending cycle.
        if (reset)   shreg = '0;
        else if (ld) shreg = d_out;
        else if (sl) shreg = {shreg[WIDTH-2:0], 1'b0};
        else if (sr) shreg = {1'b0, shreg[WIDTH-1:1]};
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_vec = (sched.size() > 0) ? sched[0] : 6'b100000;
            check("outputs{ready,busy,done,ld,sl,sr}", {cmd_ready, busy, done, ld, sl, sr}, exp_vec);
            check("d_out", d_out, exp_dout);
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", cmd_ready, 1);
    endtask

    // Returns after the accept edge; the next negedge is cycle 1.
    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] data);
        wait_idle();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n_sr;
        int acc0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_strobes", {ld, sl, sr}, 3'b000);
        check("rst_dout", d_out, 4'b0000);

        // LOAD 1011
        issue(2'b01, 3'd0, 4'b1011);
        @(negedge clk); check("load_c1_ld", ld, 1); check("load_c1_dout", d_out, 4'b1011);
        @(negedge clk); check("load_c2_ld", ld, 0); check("load_chain_out", shreg, 4'b1011);
        @(negedge clk); check("load_c3_done", done, 1); check("load_c3_ready", cmd_ready, 0);
        @(negedge clk); check("load_c4_ready", cmd_ready, 1);

        // SHL 3
        issue(2'b10, 3'd3, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("shl_c%0d_sl", k), sl, (k % 2 == 1 && k <= 5) ? 1 : 0);
            check($sformatf("shl_c%0d_done", k), done, (k == 7) ? 1 : 0);
            check($sformatf("shl_c%0d_ldsr", k), {ld, sr}, 2'b00);
        end
        check("shl_c8_ready", cmd_ready, 1);

        // SHR 0 and NOP
        for (int t = 0; t < 2; t++) begin
            issue(t == 0 ? 2'b11 : 2'b00, 3'd0, 4'b1111);
            @(negedge clk); check("zero_c1_done", done, 1); check("zero_c1_strobes", {ld, sl, sr}, 3'b000);
            @(negedge clk); check("zero_c2_ready", cmd_ready, 1);
        end

        // SHR 7 aborted by reset in cycle 6
        issue(2'b11, 3'd7, 4'b0000);
        n_sr = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_sr += int'(sr);
            check("abort_no_done", done, 0);
        end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_sr_pulses", n_sr, 3);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_sr", sr, 0);
        check("abort_dout", d_out, 4'b0000);
        repeat (4) begin @(negedge clk); check("abort_done_later", done, 0); end

        // Back-to-back with cmd_valid held: LOAD then SHL 1
        wait_idle();
        acc0 = accepts;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'b0101; cmd_cnt = 3'd5;
        @(posedge clk); #1;
        cmd_op = 2'b10; cmd_cnt = 3'd1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 3) check("b2b_not_ready", cmd_ready, 0);
            if (k == 3) check("b2b_done1", done, 1);
            if (k == 4) check("b2b_ready_c4", cmd_ready, 1);
            if (k == 5) begin check("b2b_c5_busy", busy, 1); check("b2b_c5_sl", sl, 1); cmd_valid = 1'b0; end
            if (k == 7) check("b2b_done2", done, 1);
        end
        check("b2b_accepts", accepts - acc0, 2);

        // Randomized traffic
        repeat (1500) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 99) == 0);
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_op    = 2'($urandom);
            cmd_cnt   = CNT_W'($urandom);
            cmd_data  = WIDTH'($urandom);
        end
        @(posedge clk); #1;
        reset = 1'b0; cmd_valid = 1'b0;
        repeat (40) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
